mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Multicycle main control unit for the simplified MIPS core: the controlling end of the datapath's
//  control interface (RegWrite, RegDst, ALUSrc, branch/PC select, ALU function).
//  Decodes opcode/funct from the instruction register, sequences each instruction through a Moore FSM,
//  and stalls on a shared instruction/data memory via a ready handshake.
// PARAMETERS
//  MEM_WAIT_MAX  15  max cycles any memory state waits for mem_ready before timing out (1..255)
// PORTS
//  clk            in   1  clock, rising edge
//  rstn           in   1  reset, asynchronous, active-low
//  opcode         in   6  instr[31:26] from instruction register
//  funct          in   6  instr[5:0] from instruction register
//  zero           in   1  ALU z_flag
//  mem_ready      in   1  memory completes the current access this cycle
//  i_or_d         out  1  memory address select: 0=PC, 1=ALUOut
//  mem_read       out  1  memory read request
//  mem_write      out  1  memory write request
//  ir_write       out  1  load instruction register
//  reg_write      out  1  register file wr_en
//  reg_dst        out  1  wr_addr select: 0=rt, 1=rd
//  mem_to_reg     out  1  wr_data select: 0=ALUOut, 1=MDR
//  alu_src_a      out  1  ALU in1: 0=PC, 1=rd_data1
//  alu_src_b      out  2  ALU in2: 0=rd_data2, 1=const 4, 2=sig_ext_out, 3=sig_ext_out<<2
//  alu_func       out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT
//  pc_src         out  2  next PC: 0=ALU result, 1=ALUOut, 2=jump target
//  pc_en          out  1  PC load enable = pc_write | (pc_write_cond & zero)
//  illegal_op     out  1  1-cycle pulse: unsupported opcode/funct decoded
//  mem_err        out  1  1-cycle pulse: memory wait exceeded MEM_WAIT_MAX
// BEHAVIOUR
//  - States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB[, JUMP].
//  - Reset: state=FETCH, wait counter=0; outputs decoded from FETCH, so mem_read=1, alu_src_b=1,
//    alu_func=ADD; all other outputs 0. Reset mid-instruction abandons it; no writes are issued after.
//  - FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, ADD. Hold until mem_ready; in that cycle
//    ir_write=1, pc_en=1, pc_src=0, then go to DECODE.
//  - DECODE: alu_src_a=0, alu_src_b=3, ADD (branch target). Next by opcode: 100011/101011->MEMADR,
//    000000->EXEC, 000100->BRANCH, 001000->ADDIEX, 000010->JUMP (macro only); else illegal_op=1 -> FETCH.
//  - MEMADR: alu_src_a=1, alu_src_b=2, ADD; -> MEMRD (lw) or MEMWR (sw).
//  - MEMRD: mem_read=1, i_or_d=1; wait mem_ready -> MEMWB. MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH.
//  - MEMWR: mem_write=1, i_or_d=1; wait mem_ready -> FETCH.
//  - EXEC: alu_src_a=1, alu_src_b=0; funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT;
//    other funct: illegal_op=1, no writeback, -> FETCH. Legal -> ALUWB: reg_write=1, reg_dst=1 -> FETCH.
//  - BRANCH: alu_src_a=1, alu_src_b=0, SUB, pc_src=1, pc_write_cond internal; pc_en=zero -> FETCH.
//  - ADDIEX: alu_src_a=1, alu_src_b=2, ADD -> ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
//  - Wait states (FETCH, MEMRD, MEMWR): counter clears on entry and increments per cycle without mem_ready.
//    mem_ready in the same cycle as count==MEM_WAIT_MAX counts as completion. Count reaching MEM_WAIT_MAX
//    without mem_ready: mem_err=1, no ir_write/pc_en/state writes, -> FETCH. Counter saturates, never wraps.
//  - mem_read and mem_write are never high together. reg_write only in MEMWB/ALUWB/ADDIWB.
//  - CPI: R-type/addi 4, sw 4, lw 5, beq 3, j 3, plus memory wait cycles.
// CONFIGURATION
//  MIPS_JUMP_EN defined: JUMP state present; opcode 000010 -> JUMP: pc_src=2, pc_en=1 -> FETCH.
//  MIPS_JUMP_EN undefined: no JUMP state; opcode 000010 raises illegal_op in DECODE; pc_src never 2.
// TESTING
//  1 Reset asserted mid-MEMRD -> next cycle state=FETCH, mem_read=1, reg_write=0 and no MEMWB.
//  2 lw (100011), mem_ready high on 3rd MEMRD cycle -> reg_write with mem_to_reg=1 on 7th cycle after FETCH.
//  3 R-type funct 100010 -> EXEC alu_func=0110; ALUWB reg_write=1, reg_dst=1; 4 cycles total.
//  4 beq with zero=1 -> pc_en=1, pc_src=1 in BRANCH; with zero=0 -> pc_en=0.
//  5 mem_ready held low in FETCH, MEM_WAIT_MAX=15 -> mem_err pulse; no ir_write; back in FETCH.
//  6 opcode 000010 -> pc_en=1, pc_src=2 with MIPS_JUMP_EN; illegal_op pulse without it.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle main control unit for the simplified MIPS core.
// Moore FSM sequencing FETCH/DECODE/execute/writeback, stalling on a shared
// memory via mem_ready, with a per-access wait limit (MEM_WAIT_MAX).
// Optional feature: define MIPS_JUMP_EN to add the JUMP state for opcode 000010.
// Memory handshake: a request (mem_read or mem_write) is held for as long as the
// FSM sits in FETCH/MEMRD/MEMWR; the access completes in the cycle mem_ready=1,
// and only then does the FSM advance or issue ir_write/pc_en.
module mips_multicycle_ctrl #(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_func,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       illegal_op,
    output logic       mem_err,
    output logic [3:0] dbg_state
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_ADDIEX = 4'd9;
    localparam logic [3:0] S_ADDIWB = 4'd10;
`ifdef MIPS_JUMP_EN
    localparam logic [3:0] S_JUMP   = 4'd11;
    localparam logic [5:0] OP_J     = 6'b000010;
`endif

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

    logic [3:0] state, state_next;
    logic [7:0] wait_cnt, wait_cnt_next;
    logic       waiting, timeout;
    logic [3:0] exec_func;
    logic       funct_ok;
    logic       pc_write, pc_write_cond;

    // Memory states and the wait-limit condition (only without mem_ready).
    assign waiting = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    assign timeout = waiting && !mem_ready && (wait_cnt == WAIT_MAX);

    // R-type funct decode into the ALU operation.
    always_comb begin
        exec_func = ALU_ADD;
        funct_ok  = 1'b1;
        case (funct)
            6'b100000: exec_func = ALU_ADD;
            6'b100010: exec_func = ALU_SUB;
            6'b100100: exec_func = ALU_AND;
            6'b100101: exec_func = ALU_OR;
            6'b101010: exec_func = ALU_SLT;
            default:   funct_ok  = 1'b0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:  if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXEC;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_ADDI:      state_next = S_ADDIEX;
`ifdef MIPS_JUMP_EN
                    OP_J:         state_next = S_JUMP;
`endif
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR: state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  begin
                if (mem_ready)    state_next = S_MEMWB;
                else if (timeout) state_next = S_FETCH;
            end
            S_MEMWR:  if (mem_ready || timeout) state_next = S_FETCH;
            S_EXEC:   state_next = funct_ok ? S_ALUWB : S_FETCH;
            S_ADDIEX: state_next = S_ADDIWB;
            default:  state_next = S_FETCH;
        endcase
    end

    // Wait counter: cleared on any state entry (including FETCH->FETCH after a
    // timeout), counts stalled cycles, saturates at the limit.
    always_comb begin
        wait_cnt_next = 8'd0;
        if (waiting && (state_next == state) && !timeout && !mem_ready && (wait_cnt < WAIT_MAX))
            wait_cnt_next = wait_cnt + 8'd1;
        else if (waiting && (state_next == state) && !timeout && !mem_ready)
            wait_cnt_next = wait_cnt;
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_FETCH;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Output decode from state (plus mem_ready/zero/opcode/funct qualifiers).
    always_comb begin
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        alu_func      = ALU_ADD;
        pc_src        = 2'd0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        illegal_op    = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'd3;
                illegal_op = (state_next == S_FETCH);
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_EXEC: begin
                alu_src_a  = 1'b1;
                alu_func   = exec_func;
                illegal_op = !funct_ok;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_func      = ALU_SUB;
                pc_src        = 2'd1;
                pc_write_cond = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
            end
            S_ADDIWB: reg_write = 1'b1;
`ifdef MIPS_JUMP_EN
            S_JUMP: begin
                pc_src   = 2'd2;
                pc_write = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign pc_en     = pc_write | (pc_write_cond & zero);
    assign mem_err   = timeout;
    assign dbg_state = state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: table-driven check of the multicycle control FSM,
// plus hand-written sequences for reset mid-access and memory wait limits.
// Honours MIPS_JUMP_EN for the jump opcode expectations.
module tb_mips_multicycle_ctrl;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_ADDIEX = 4'd9;
    localparam logic [3:0] S_ADDIWB = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;

    localparam logic [3:0] F_AND = 4'b0000;
    localparam logic [3:0] F_OR  = 4'b0001;
    localparam logic [3:0] F_ADD = 4'b0010;
    localparam logic [3:0] F_SUB = 4'b0110;
    localparam logic [3:0] F_SLT = 4'b0111;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
    localparam logic [5:0] BAD = 6'b111111;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [5:0] opcode = 6'd0, funct = 6'd0;
    logic       zero = 1'b0, mem_ready = 1'b0;
    logic       i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [3:0] alu_func, dbg_state;
    logic       pc_en, illegal_op, mem_err;

    int checks = 0;
    int errors = 0;

    // Clock and DUT.
    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.MEM_WAIT_MAX(15)) dut (
        .clk(clk), .rstn(rstn), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_func(alu_func), .pc_src(pc_src),
        .pc_en(pc_en), .illegal_op(illegal_op), .mem_err(mem_err), .dbg_state(dbg_state)
    );

    // Observed bundle: {state, iod, mr, mw, irw, rw, rd, m2r, sa, sb, func, ps, pe, ill, err}.
    logic [22:0] got;
    assign got = {dbg_state, i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst,
                  mem_to_reg, alu_src_a, alu_src_b, alu_func, pc_src, pc_en, illegal_op, mem_err};

    function automatic logic [18:0] mk(logic iod, logic mr, logic mw, logic irw, logic rw,
                                       logic rd, logic m2r, logic sa, logic [1:0] sb,
                                       logic [3:0] fn, logic [1:0] ps, logic pe, logic ill,
                                       logic err);
        return {iod, mr, mw, irw, rw, rd, m2r, sa, sb, fn, ps, pe, ill, err};
    endfunction

    // Expected outputs per state, written from the control-signal table.
    function automatic logic [18:0] o_fetch(logic rdy, logic err);
        return mk(0, 1, 0, rdy, 0, 0, 0, 0, 2'd1, F_ADD, 2'd0, rdy, 0, err);
    endfunction
    function automatic logic [18:0] o_decode(logic ill);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd3, F_ADD, 2'd0, 0, ill, 0);
    endfunction
    function automatic logic [18:0] o_memadr();
        return mk(0, 0, 0, 0, 0, 0, 0, 1, 2'd2, F_ADD, 2'd0, 0, 0, 0);
    endfunction
    function automatic logic [18:0] o_memrd(logic err);
        return mk(1, 1, 0, 0, 0, 0, 0, 0, 2'd0, F_ADD, 2'd0, 0, 0, err);
    endfunction
    function automatic logic [18:0] o_memwb();
        return mk(0, 0, 0, 0, 1, 0, 1, 0, 2'd0, F_ADD, 2'd0, 0, 0, 0);
    endfunction
    function automatic logic [18:0] o_memwr(logic err);
        return mk(1, 0, 1, 0, 0, 0, 0, 0, 2'd0, F_ADD, 2'd0, 0, 0, err);
    endfunction
    function automatic logic [18:0] o_exec(logic [3:0] fn, logic ill);
        return mk(0, 0, 0, 0, 0, 0, 0, 1, 2'd0, fn, 2'd0, 0, ill, 0);
    endfunction
    function automatic logic [18:0] o_aluwb();
        return mk(0, 0, 0, 0, 1, 1, 0, 0, 2'd0, F_ADD, 2'd0, 0, 0, 0);
    endfunction
    function automatic logic [18:0] o_branch(logic pe);
        return mk(0, 0, 0, 0, 0, 0, 0, 1, 2'd0, F_SUB, 2'd1, pe, 0, 0);
    endfunction
    function automatic logic [18:0] o_addiex();
        return mk(0, 0, 0, 0, 0, 0, 0, 1, 2'd2, F_ADD, 2'd0, 0, 0, 0);
    endfunction
    function automatic logic [18:0] o_addiwb();
        return mk(0, 0, 0, 0, 1, 0, 0, 0, 2'd0, F_ADD, 2'd0, 0, 0, 0);
    endfunction
    function automatic logic [18:0] o_jump();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd0, F_ADD, 2'd2, 1, 0, 0);
    endfunction

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        rdy;
        logic [3:0]  st;
        logic [18:0] out;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic rdy, input logic [3:0] st, input logic [18:0] out);
        vec_t v;
        v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.st = st; v.out = out;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [22:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got state=%0d ctl=%05h, expected state=%0d ctl=%05h",
                     name, got[22:19], got[18:0], exp[22:19], exp[18:0]);
        end
    endtask

    // Drive one cycle's inputs just after a falling edge, check, then advance.
    task automatic cycle(input string name, input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input logic rdy, input logic [3:0] st,
                         input logic [18:0] out);
        opcode = op; funct = fn; zero = z; mem_ready = rdy;
        #1;
        check(name, {st, out});
        @(negedge clk);
    endtask

    initial begin
        // lw, mem_ready on the 3rd MEMRD cycle: writeback on 7th cycle
        add(LW, 0, 0, 1, S_FETCH,  o_fetch(1, 0));
        add(LW, 0, 0, 0, S_DECODE, o_decode(0));
        add(LW, 0, 0, 0, S_MEMADR, o_memadr());
        add(LW, 0, 0, 0, S_MEMRD,  o_memrd(0));
        add(LW, 0, 0, 0, S_MEMRD,  o_memrd(0));
        add(LW, 0, 0, 1, S_MEMRD,  o_memrd(0));
        add(LW, 0, 0, 0, S_MEMWB,  o_memwb());
        // sw
        add(SW, 0, 0, 1, S_FETCH,  o_fetch(1, 0));
        add(SW, 0, 0, 0, S_DECODE, o_decode(0));
        add(SW, 0, 0, 0, S_MEMADR, o_memadr());
        add(SW, 0, 0, 1, S_MEMWR,  o_memwr(0));
        // R-type sub, add, and, or, slt
        add(RT, 6'b100010, 0, 1, S_FETCH,  o_fetch(1, 0));
        add(RT, 6'b100010, 0, 0, S_DECODE, o_decode(0));
        add(RT, 6'b100010, 0, 0, S_EXEC,   o_exec(F_SUB, 0));
        add(RT, 6'b100010, 0, 0, S_ALUWB,  o_aluwb());
        add(RT, 6'b100000, 0, 1, S_FETCH,  o_fetch(1, 0));
        add(RT, 6'b100000, 0, 0, S_DECODE, o_decode(0));
        add(RT, 6'b100000, 0, 0, S_EXEC,   o_exec(F_ADD, 0));
        add(RT, 6'b100000, 0, 0, S_ALUWB,  o_aluwb());
        add(RT, 6'b100100, 0, 1, S_FETCH,  o_fetch(1, 0));
        add(RT, 6'b100100, 0, 0, S_DECODE, o_decode(0));
        add(RT, 6'b100100, 0, 0, S_EXEC,   o_exec(F_AND, 0));
        add(RT, 6'b100100, 0, 0, S_ALUWB,  o_aluwb());
        add(RT, 6'b100101, 0, 1, S_FETCH,  o_fetch(1, 0));
        add(RT, 6'b100101, 0, 0, S_DECODE, o_decode(0));
        add(RT, 6'b100101, 0, 0, S_EXEC,   o_exec(F_OR, 0));
        add(RT, 6'b100101, 0, 0, S_ALUWB,  o_aluwb());
        add(RT, 6'b101010, 0, 1, S_FETCH,  o_fetch(1, 0));
        add(RT, 6'b101010, 0, 0, S_DECODE, o_decode(0));
        add(RT, 6'b101010, 0, 0, S_EXEC,   o_exec(F_SLT, 0));
        add(RT, 6'b101010, 0, 0, S_ALUWB,  o_aluwb());
        // R-type with unsupported funct: no writeback
        add(RT, 6'b000000, 0, 1, S_FETCH,  o_fetch(1, 0));
        add(RT, 6'b000000, 0, 0, S_DECODE, o_decode(0));
        add(RT, 6'b000000, 0, 0, S_EXEC,   o_exec(F_ADD, 1));
        // beq taken / not taken
        add(BEQ, 0, 1, 1, S_FETCH,  o_fetch(1, 0));
        add(BEQ, 0, 1, 0, S_DECODE, o_decode(0));
        add(BEQ, 0, 1, 0, S_BRANCH, o_branch(1));
        add(BEQ, 0, 0, 1, S_FETCH,  o_fetch(1, 0));
        add(BEQ, 0, 0, 0, S_DECODE, o_decode(0));
        add(BEQ, 0, 0, 0, S_BRANCH, o_branch(0));
        // addi
        add(ADDI, 0, 0, 1, S_FETCH,  o_fetch(1, 0));
        add(ADDI, 0, 0, 0, S_DECODE, o_decode(0));
        add(ADDI, 0, 0, 0, S_ADDIEX, o_addiex());
        add(ADDI, 0, 0, 0, S_ADDIWB, o_addiwb());
        // j
        add(JMP, 0, 0, 1, S_FETCH,  o_fetch(1, 0));
`ifdef MIPS_JUMP_EN
        add(JMP, 0, 0, 0, S_DECODE, o_decode(0));
        add(JMP, 0, 0, 0, S_JUMP,   o_jump());
`else
        add(JMP, 0, 0, 0, S_DECODE, o_decode(1));
`endif
        // fetch with one stall cycle, then unsupported opcode
        add(BAD, 0, 0, 0, S_FETCH,  o_fetch(0, 0));
        add(BAD, 0, 0, 1, S_FETCH,  o_fetch(1, 0));
        add(BAD, 0, 0, 0, S_DECODE, o_decode(1));

        // Reset state
        rstn = 1'b0;
        #2;
        check("reset", {S_FETCH, o_fetch(0, 0)});
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        foreach (vecs[i])
            cycle($sformatf("vec%0d", i), vecs[i].op, vecs[i].fn, vecs[i].z, vecs[i].rdy,
                  vecs[i].st, vecs[i].out);

        // FETCH stall to the limit: 15 quiet cycles, error on the 16th, back in FETCH
        for (int i = 0; i < 15; i++)
            cycle($sformatf("fetch_wait%0d", i), BAD, 0, 0, 0, S_FETCH, o_fetch(0, 0));
        cycle("fetch_timeout", BAD, 0, 0, 0, S_FETCH, o_fetch(0, 1));
        // Counter restarted: 15 more quiet cycles, ready on the limit cycle completes
        for (int i = 0; i < 15; i++)
            cycle($sformatf("fetch_rewait%0d", i), BAD, 0, 0, 0, S_FETCH, o_fetch(0, 0));
        cycle("fetch_ready_at_max", BAD, 0, 0, 1, S_FETCH, o_fetch(1, 0));
        cycle("after_max_decode", BAD, 0, 0, 0, S_DECODE, o_decode(1));

        // sw with a memory that never answers
        cycle("sw_to_fetch", SW, 0, 0, 1, S_FETCH, o_fetch(1, 0));
        cycle("sw_decode", SW, 0, 0, 0, S_DECODE, o_decode(0));
        cycle("sw_memadr", SW, 0, 0, 0, S_MEMADR, o_memadr());
        for (int i = 0; i < 15; i++)
            cycle($sformatf("memwr_wait%0d", i), SW, 0, 0, 0, S_MEMWR, o_memwr(0));
        cycle("memwr_timeout", SW, 0, 0, 0, S_MEMWR, o_memwr(1));
        cycle("memwr_back_fetch", SW, 0, 0, 0, S_FETCH, o_fetch(0, 0));

        // Reset asserted mid-MEMRD abandons the load
        cycle("rst_lw_fetch", LW, 0, 0, 1, S_FETCH, o_fetch(1, 0));
        cycle("rst_lw_decode", LW, 0, 0, 0, S_DECODE, o_decode(0));
        cycle("rst_lw_memadr", LW, 0, 0, 0, S_MEMADR, o_memadr());
        opcode = LW; mem_ready = 1'b0;
        #1;
        check("rst_lw_memrd", {S_MEMRD, o_memrd(0)});
        #1;
        rstn = 1'b0;
        #1;
        check("rst_async_fetch", {S_FETCH, o_fetch(0, 0)});
        @(negedge clk);
        check("rst_held_no_memwb", {S_FETCH, o_fetch(0, 0)});
        rstn = 1'b1;
        @(negedge clk);
        cycle("rst_released", LW, 0, 0, 0, S_FETCH, o_fetch(0, 0));
        cycle("rst_after_fetch", BAD, 0, 0, 1, S_FETCH, o_fetch(1, 0));
        cycle("rst_after_decode", BAD, 0, 0, 0, S_DECODE, o_decode(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, expected completion before 100000");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
